// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared types and helpers for the button debouncer
// Contents:
//   btn_state_t  per-channel debounce FSM state (2-bit encoding)
//   cnt_width()  register width able to hold values 0..n-1 (minimum 1 bit)
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  // A terminal value of n-1 needs clog2(n) bits; never return 0 so a
  // degenerate parameter still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - pad-side and PIO-side button signals bundle
// Signals (all NUM_BTN wide):
//   raw_btn        asynchronous pad inputs
//   btn_level      debounced level, 1 = pressed (to PIO in_port)
//   press_pulse    one-cycle strobe on accepted press
//   release_pulse  one-cycle strobe on accepted release
//   long_press     one-cycle strobe, at most once per press
// Modports: master = debouncer side, slave = pad driver / consumer side.
interface button_debouncer_if #(
  parameter int NUM_BTN = 4
);

  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] press_pulse;
  logic [NUM_BTN-1:0] release_pulse;
  logic [NUM_BTN-1:0] long_press;

  modport master (
    input  raw_btn,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_press
  );

  modport slave (
    output raw_btn,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_press
  );

endinterface

// File: rtl/button_debounce_channel.sv
// rtl/button_debounce_channel.sv - one debounced button: synchroniser, FSM, counters
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   raw_btn        asynchronous pad input
//   btn_level      registered debounced level, 1 = pressed
//   press_pulse    registered one-cycle strobe on accepted press
//   release_pulse  registered one-cycle strobe on accepted release
//   long_press     registered one-cycle strobe after LONG_PRESS_CYCLES held
module button_debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press
);

  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  // Pad level when nobody is pressing the button.
  localparam logic IDLE_PAD = ACTIVE_LOW;

  logic s1;
  logic s2;
  logic pressed;

  btn_state_t        state;
  btn_state_t        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] hold_next;

  logic level_next;
  logic press_next;
  logic release_next;
  logic long_next;

  // Synchroniser resets to the idle pad value so reset exit never looks
  // like a press edge; a button held through reset is qualified afresh.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= IDLE_PAD;
      s2 <= IDLE_PAD;
    end else begin
      s1 <= raw_btn;
      s2 <= s1;
    end
  end

  assign pressed = s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      hold          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      hold          <= hold_next;
      btn_level     <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      long_press    <= long_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    press_next   = 1'b0;
    release_next = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pressed) begin
          state_next = ST_PRESS_WAIT;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!pressed) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_PRESSED;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      ST_PRESSED: begin
        if (!pressed) begin
          state_next = ST_RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = '0;
        end
      end

      ST_RELEASE_WAIT: begin
        if (pressed) begin
          state_next = ST_PRESSED;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = ST_IDLE;
          cnt_next     = '0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Hold counter: restarts on an accepted press, keeps running through a
  // release glitch, saturates at the terminal value so long_press fires once.
  always_comb begin
    hold_next = hold;
    long_next = 1'b0;
    if (press_next) begin
      hold_next = '0;
    end else if (state == ST_PRESSED || state == ST_RELEASE_WAIT) begin
      if (hold != HOLD_LAST) begin
        hold_next = hold + HOLD_ONE;
        long_next = (hold_next == HOLD_LAST);
      end
    end else begin
      hold_next = '0;
    end
  end

  assign level_next = (state_next == ST_PRESSED) || (state_next == ST_RELEASE_WAIT);

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - multi-channel push-button debouncer feeding the PIO in_port
// Ports:
//   clk      system clock, single domain
//   reset_n  asynchronous active-low reset
//   btn_if   master side of button_debouncer_if: raw_btn in; btn_level,
//            press_pulse, release_pulse, long_press out (NUM_BTN wide)
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int NUM_BTN           = 4,
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  button_debouncer_if.master btn_if
);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] press_w;
  logic [NUM_BTN-1:0] release_w;
  logic [NUM_BTN-1:0] long_w;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    button_debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .raw_btn      (btn_if.raw_btn[i]),
      .btn_level    (level_w[i]),
      .press_pulse  (press_w[i]),
      .release_pulse(release_w[i]),
      .long_press   (long_w[i])
    );
  end

  assign btn_if.btn_level     = level_w;
  assign btn_if.press_pulse   = press_w;
  assign btn_if.release_pulse = release_w;
  assign btn_if.long_press    = long_w;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  button_debouncer_if #(.NUM_BTN(NB)) btn_if ();

  button_debouncer #(
    .NUM_BTN          (NB),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(10),
    .ACTIVE_LOW       (1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_if (btn_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] lvl, input logic [3:0] pr,
                            input logic [3:0] rl, input logic [3:0] lg);
    check({tag, ".level"},   32'(btn_if.btn_level),     32'(lvl));
    check({tag, ".press"},   32'(btn_if.press_pulse),   32'(pr));
    check({tag, ".release"}, 32'(btn_if.release_pulse), 32'(rl));
    check({tag, ".long"},    32'(btn_if.long_press),    32'(lg));
  endtask

  task automatic step(input string tag, input logic [3:0] lvl, input logic [3:0] pr,
                      input logic [3:0] rl, input logic [3:0] lg);
    @(posedge clk);
    #1;
    check_outs(tag, lvl, pr, rl, lg);
  endtask

  initial begin
    btn_if.raw_btn = 4'b0000;

    // Reset with all pads reading "pressed".
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset_hold", 4'h0, 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++)
      step("reset_exit", (e >= 6) ? 4'hF : 4'h0, (e == 6) ? 4'hF : 4'h0, 4'h0, 4'h0);
    btn_if.raw_btn = 4'b1111;
    for (int e = 1; e <= 6; e++)
      step("reset_rel", (e < 6) ? 4'hF : 4'h0, 4'h0, (e == 6) ? 4'hF : 4'h0, 4'h0);
    step("idle", 4'h0, 4'h0, 4'h0, 4'h0);

    // Clean press on ch0 held 20 cycles; long press fires 10 after press.
    btn_if.raw_btn = 4'b1110;
    for (int e = 1; e <= 20; e++)
      step("clean_press", (e >= 6) ? 4'h1 : 4'h0, (e == 6) ? 4'h1 : 4'h0, 4'h0,
           (e == 16) ? 4'h1 : 4'h0);
    btn_if.raw_btn = 4'b1111;
    for (int e = 1; e <= 7; e++)
      step("clean_rel", (e < 6) ? 4'h1 : 4'h0, 4'h0, (e == 6) ? 4'h1 : 4'h0, 4'h0);

    // Bounce on ch1: toggles every 2 cycles, never stable long enough.
    for (int e = 0; e < 30; e++) begin
      btn_if.raw_btn = {2'b11, 1'((e / 2) % 2), 1'b1};
      step("bounce", 4'h0, 4'h0, 4'h0, 4'h0);
    end
    btn_if.raw_btn = 4'b1111;
    for (int e = 1; e <= 8; e++)
      step("bounce_end", 4'h0, 4'h0, 4'h0, 4'h0);

    // Long press on ch2 held 40 cycles: exactly one long_press strobe.
    btn_if.raw_btn = 4'b1011;
    for (int e = 1; e <= 40; e++)
      step("long", (e >= 6) ? 4'h4 : 4'h0, (e == 6) ? 4'h4 : 4'h0, 4'h0,
           (e == 16) ? 4'h4 : 4'h0);
    btn_if.raw_btn = 4'b1111;
    for (int e = 1; e <= 7; e++)
      step("long_rel", (e < 6) ? 4'h4 : 4'h0, 4'h0, (e == 6) ? 4'h4 : 4'h0, 4'h0);

    // Release glitch on ch3: 2-cycle high blip while pressed is rejected,
    // and the hold counter keeps running across it.
    btn_if.raw_btn = 4'b0111;
    for (int e = 1; e <= 20; e++) begin
      btn_if.raw_btn = (e == 9 || e == 10) ? 4'b1111 : 4'b0111;
      step("glitch", (e >= 6) ? 4'h8 : 4'h0, (e == 6) ? 4'h8 : 4'h0, 4'h0,
           (e == 16) ? 4'h8 : 4'h0);
    end
    btn_if.raw_btn = 4'b1111;
    for (int e = 1; e <= 7; e++)
      step("glitch_rel", (e < 6) ? 4'h8 : 4'h0, 4'h0, (e == 6) ? 4'h8 : 4'h0, 4'h0);

    // Reset mid-press on ch0: asynchronous clear, button still held after
    // release so it is accepted as a fresh press with no release strobe.
    btn_if.raw_btn = 4'b1110;
    for (int e = 1; e <= 8; e++)
      step("mid_press", (e >= 6) ? 4'h1 : 4'h0, (e == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0);
    reset_n = 1'b0;
    #2;
    check_outs("mid_reset", 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    check_outs("mid_reset_hold", 4'h0, 4'h0, 4'h0, 4'h0);
    reset_n = 1'b1;
    for (int e = 1; e <= 7; e++)
      step("mid_exit", (e >= 6) ? 4'h1 : 4'h0, (e == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0);
    btn_if.raw_btn = 4'b1111;
    for (int e = 1; e <= 7; e++)
      step("mid_rel", (e < 6) ? 4'h1 : 4'h0, 4'h0, (e == 6) ? 4'h1 : 4'h0, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Multi-channel debouncer for the board push-buttons; sits directly upstream of the Avalon PIO button port.
- Synchronises raw, bouncing, possibly active-low pad inputs and qualifies each level change over a programmable stable interval.
- Drives a clean active-high level into the PIO `in_port`, so the PIO's rising-edge capture and IRQ fire exactly once per physical press.
- Also provides per-channel press, release and long-press strobes for local logic.

Parameters:
- NUM_BTN, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a change (20 ms at 50 MHz); legal minimum 2.
- LONG_PRESS_CYCLES, 50000000, cycles in the pressed state before `long_press` fires (1 s at 50 MHz); must be greater than 0.
- ACTIVE_LOW, 1, 1 means the raw pad reads 0 when pressed; 0 means it reads 1 when pressed.

Ports:
- clk  input  1  system clock; single clock domain.
- reset_n  input  1  asynchronous, active-low reset.
- raw_btn  input  NUM_BTN  asynchronous pad inputs.
- btn_level  output  NUM_BTN  debounced level, 1 = pressed; connects to the PIO `in_port`.
- press_pulse  output  NUM_BTN  one-cycle strobe on an accepted press.
- release_pulse  output  NUM_BTN  one-cycle strobe on an accepted release.
- long_press  output  NUM_BTN  one-cycle strobe, at most once per press.

Behaviour:
- Clock and reset:
  - One clock domain; reset is asynchronous and active-low.
  - All outputs reset to 0.
  - Synchroniser flops reset to the idle pad value (1 if ACTIVE_LOW, else 0), so no spurious press occurs out of reset.
- Input conditioning, per channel:
  - 2-flop synchroniser `s1` then `s2`.
  - `p = s2 XOR ACTIVE_LOW`, giving an active-high pressed sample.
- FSM, per channel; states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: if p=1, go to PRESS_WAIT with cnt=1.
  - PRESS_WAIT:
    - If p=0, go to IDLE with cnt=0; no strobes.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to PRESSED.
    - Else cnt+1.
  - PRESSED: if p=0, go to RELEASE_WAIT with cnt=1.
  - RELEASE_WAIT:
    - If p=1, go to PRESSED with cnt=0; no strobes, hold counter keeps running.
    - Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE.
    - Else cnt+1.
- Outputs, all registered, no combinational path from `raw_btn`:
  - `btn_level` = 1 in PRESSED and RELEASE_WAIT.
  - `press_pulse` = 1 for the single cycle after the PRESS_WAIT to PRESSED transition.
  - `release_pulse` = 1 for the single cycle after the RELEASE_WAIT to IDLE transition.
- Latency:
  - Edge 1 is the first edge that samples the new raw value.
  - With a clean input, `btn_level` and the matching strobe update on edge DEBOUNCE_CYCLES+2.
- Long press:
  - Hold counter clears when entering PRESSED from PRESS_WAIT.
  - It increments every cycle while in PRESSED or RELEASE_WAIT.
  - When it reaches LONG_PRESS_CYCLES, `long_press` pulses for 1 cycle and the counter saturates; no re-fire until the next accepted press.
  - Cleared in IDLE.
- Widths:
  - cnt width = clog2(DEBOUNCE_CYCLES).
  - Hold counter width = clog2(LONG_PRESS_CYCLES+1).
  - No wrap-around; counters never exceed their terminal value.
- Boundary conditions:
  - Channels are fully independent; simultaneous presses produce simultaneous strobes.
  - A bounce on the last counting cycle still aborts the change.
  - Reset asserted mid-operation clears all state immediately, with no `release_pulse` on reset exit.
  - A button held through reset release is accepted as a fresh press after DEBOUNCE_CYCLES+2 edges.

Decomposition:
- Package `button_debouncer_pkg`:
  - State enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; 2-bit encoding).
  - Counter-width function.
- Sub-module `button_debounce_channel`:
  - Contains one synchroniser, FSM and the two counters.
  - Instantiated NUM_BTN times by a generate loop in the top level.

Test Plan (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, ACTIVE_LOW=1, NUM_BTN=4):
- Reset:
  - Stimulus: hold `reset_n` low with `raw_btn` = 4'b0000.
  - Required: all outputs 0.
  - After release, with `raw_btn` still 4'b0000: `btn_level[3:0]` = 4'b1111 and `press_pulse` = 4'b1111 for exactly one cycle, on edge 6.
- Clean press/release:
  - Stimulus: `raw_btn[0]` 1 to 0, hold 20 cycles, then 0 to 1.
  - Required: `btn_level[0]` rises on edge 6 with `press_pulse[0]` high 1 cycle.
  - Required: `btn_level[0]` falls 6 edges after the release with `release_pulse[0]` high 1 cycle.
- Bounce:
  - Stimulus: `raw_btn[1]` toggles every 2 cycles for 30 cycles, then returns to 1.
  - Required: `btn_level[1]` stays 0; no strobes on any output.
- Long press:
  - Stimulus: hold `raw_btn[2]`=0 for 40 cycles.
  - Required: `long_press[2]` high exactly once, 10 cycles after `press_pulse[2]`.
- Release glitch:
  - Stimulus: while pressed, `raw_btn[3]`=1 for 2 cycles, then 0 again.
  - Required: `btn_level[3]` stays 1; no `release_pulse`.
- Reset mid-press:
  - Stimulus: pull `reset_n` low while `btn_level[0]`=1.
  - Required: outputs go to 0 asynchronously; no `release_pulse` after reset is released.
